// File: rtl/cache_act_ctrl.sv
// Activation cache sequencer: admits GLB rows into a circular RAM buffer, issues
// K-row sliding-window read passes to the PE array and tracks buffer occupancy.
module cache_act_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int ROWS_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  cfg_start,
  input  logic [ROWS_WIDTH-1:0] cfg_rows,
  input  logic [1:0]            cfg_k,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic                  drain_ready,
  output logic                  ram_write_req,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_read_req,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  done,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  // Handshakes: a row moves on the fill side when fill_valid & fill_ready, and
  // on the drain side when ram_read_req (drain_ready already folded in); both
  // sides are suppressed entirely while clk_en is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PASS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state_q, state_d;
  logic [ROWS_WIDTH-1:0]   rows_q, rows_d;
  logic [1:0]              k_q, k_d;
  logic [ROWS_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ROWS_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [1:0]              offset_q, offset_d;
  logic [ADDR_WIDTH:0]     occ_q, occ_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    active;
  logic                    wr_fire;
  logic                    read_fire;
  logic                    pass_end;
  logic                    final_pass;
  logic                    cfg_illegal;
  logic [ADDR_WIDTH:0]     free_cnt;

  always_comb begin
    active      = (state_q == S_WAIT) || (state_q == S_PASS);
    fill_ready  = clk_en && active && !full_q && (wr_cnt_q < rows_q);
    wr_fire     = fill_valid && fill_ready;
    read_fire   = clk_en && drain_ready && (state_q == S_PASS);
    pass_end    = read_fire && (offset_q == (k_q - 2'd1));
    // Passes are numbered from 0, so pass rows-K is the last one.
    final_pass  = !(pass_cnt_q < (rows_q - ROWS_WIDTH'(k_q)));
    cfg_illegal = (cfg_k == 2'd0) || (cfg_rows == '0) ||
                  (cfg_rows < ROWS_WIDTH'(cfg_k)) ||
                  ((ADDR_WIDTH+1)'(cfg_k) > DEPTH_OCC);
    free_cnt    = '0;
    if (pass_end) begin
      free_cnt = final_pass ? (ADDR_WIDTH+1)'(k_q) : (ADDR_WIDTH+1)'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    k_d        = k_q;
    wr_cnt_d   = wr_cnt_q;
    pass_cnt_d = pass_cnt_q;
    base_d     = base_q;
    offset_d   = offset_q;
    cfg_err_d  = cfg_err_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          rows_d     = cfg_rows;
          k_d        = cfg_k;
          wr_cnt_d   = '0;
          pass_cnt_d = '0;
          base_d     = '0;
          offset_d   = '0;
          cfg_err_d  = cfg_illegal;
          state_d    = cfg_illegal ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (occ_q >= (ADDR_WIDTH+1)'(k_q)) begin
          state_d  = S_PASS;
          offset_d = '0;
        end
      end
      S_PASS: begin
        if (pass_end) begin
          offset_d   = '0;
          pass_cnt_d = pass_cnt_q + 1'b1;
          if (final_pass) begin
            base_d  = base_q + ADDR_WIDTH'(k_q);
            state_d = S_DONE;
          end else begin
            base_d  = base_q + 1'b1;
            state_d = S_WAIT;
          end
        end else if (read_fire) begin
          offset_d = offset_q + 2'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    occ_d      = occ_q + (ADDR_WIDTH+1)'(wr_fire) - free_cnt;
    full_d     = (occ_d == DEPTH_OCC);
    empty_d    = (occ_d == '0);
    rd_valid_d = read_fire;
    rd_last_d  = pass_end;
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      k_q        <= '0;
      wr_cnt_q   <= '0;
      pass_cnt_q <= '0;
      base_q     <= '0;
      offset_q   <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      k_q        <= k_d;
      wr_cnt_q   <= wr_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      occ_q      <= occ_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign ram_write_req = wr_fire;
  assign ram_wr_addr   = wr_cnt_q[ADDR_WIDTH-1:0];
  assign ram_read_req  = read_fire;
  assign ram_rd_addr   = base_q + ADDR_WIDTH'(offset_q);
  assign rd_valid      = rd_valid_q;
  assign rd_last       = rd_last_q;
  assign occupancy     = occ_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/cache_act_ctrl.md
# cache_act_ctrl

Sequencing controller for the activation cache RAM: admits activation rows from the global-buffer fill side, issues sliding-window read passes to the PE array, and tracks occupancy of the circular row buffer. Each window pass reads K consecutive rows (K = kernel height, 1..3). On completion, one row (or all K on the final pass) is freed for overwrite. The block sits between the GLB fill interface, the PE drain interface and a dual-port `ram` of depth 2^ADDR_WIDTH.

## Interface
- ADDR_WIDTH, 6, cache row-address width; depth = 2^ADDR_WIDTH rows
- ROWS_WIDTH, 16, width of layer row counters
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  global enable; low = every register holds, all request/ready outputs forced 0
- cfg_start  in  1  start-layer pulse, accepted only in IDLE
- cfg_rows  in  ROWS_WIDTH  total rows in layer, sampled on cfg_start
- cfg_k  in  2  window height K, sampled on cfg_start
- fill_valid  in  1  GLB offers a row
- fill_ready  out  1  controller accepts row this cycle
- drain_ready  in  1  PE array can take a row this cycle
- ram_write_req  out  1  RAM write strobe (= fill_valid & fill_ready)
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- ram_read_req  out  1  RAM read strobe
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- rd_valid  out  1  RAM read data valid (1 cycle after ram_read_req)
- rd_last  out  1  qualifies rd_valid: last row of current pass
- occupancy  out  ADDR_WIDTH+1  rows held
- full / empty  out  1  occupancy == 2^ADDR_WIDTH / occupancy == 0
- done  out  1  one-cycle pulse at layer end
- cfg_err  out  1  sticky until next accepted cfg_start: illegal config

## Operation
- States:
  - IDLE, WAIT, PASS, DONE.
  - Reset → IDLE.
  - All outputs reset to 0; `empty` resets to 1.
- IDLE:
  - cfg_start with clk_en → latch cfg, clear wr_cnt, base, pass_cnt, offset; go to WAIT.
  - Illegal config → cfg_err=1, go to DONE directly. Illegal means cfg_k==0, cfg_rows==0, cfg_rows<cfg_k, or cfg_k > 2^ADDR_WIDTH.
- Write path, active in WAIT and PASS:
  - fill_ready = clk_en & !full & (wr_cnt < cfg_rows).
  - ram_wr_addr = wr_cnt[ADDR_WIDTH-1:0], wrapping modulo depth.
  - Each accepted write: wr_cnt+1, occupancy+1.
- WAIT:
  - occupancy ≥ K → PASS next cycle, offset=0.
- PASS:
  - ram_read_req = clk_en & drain_ready (combinational).
  - ram_rd_addr = (base + offset) mod depth.
  - Each issued read: offset+1.
  - Read with offset==K-1 ends the pass. Then offset←0, pass_cnt+1.
    - Not final pass (pass_cnt < cfg_rows-K): base+1, occupancy-1, go to WAIT.
    - Final pass: base+K, occupancy-K, go to DONE.
  - drain_ready low mid-pass stalls; offset holds.
- DONE: done=1 for one cycle → IDLE.
- Simultaneous write and free in one cycle: occupancy = old + 1 − freed.
- cfg_start outside IDLE: ignored.
- Reset mid-operation: all state cleared and in-flight pass discarded. rd_valid is not asserted for a read issued in the reset cycle.
- Total passes = cfg_rows − K + 1.
- Total reads = K × passes.
- Total writes = cfg_rows.

## Timing
- fill_ready, ram_write_req, ram_read_req: combinational from registered state and inputs in the same cycle.
- rd_valid/rd_last: registered, 1 cycle after ram_read_req, matching the RAM's 1-cycle read latency.
- WAIT→PASS: 1 cycle after occupancy reaches K.
  - First read is issued in the first PASS cycle.
  - Back-to-back passes have a 1-cycle WAIT bubble minimum.
- occupancy/full/empty are registered and reflect writes/frees from the previous cycle.
- clk_en low freezes state, counters and rd_valid pipeline. Requests are suppressed that cycle.

## Test plan
- **K=3 layer:** ADDR_WIDTH=6, cfg_rows=5, fill_valid always 1, drain_ready always 1.
  - Required: 5 writes to addrs 0..4.
  - Required: 3 passes reading 0,1,2 / 1,2,3 / 2,3,4.
  - Required: rd_last on each 3rd rd_valid, done once, final occupancy 0.
- **Backpressure and full:** ADDR_WIDTH=2, K=2, cfg_rows=10, drain_ready=0.
  - Required: fill_ready drops after 4 writes, full=1, occupancy=4.
  - Raising drain_ready resumes fill after the first pass frees one row.
  - Write addresses wrap 3→0.
- **Simultaneous write and free:** in the cycle the pass ends while a write is accepted, occupancy is unchanged next cycle.
- **Stall and clk_en:**
  - Toggle drain_ready mid-pass and pulse clk_en low 3 cycles.
  - Required: no skipped or duplicated rd_addr; no requests while clk_en=0.
- **Illegal config:** cfg_rows=2, cfg_k=3 → cfg_err=1, done pulse, no RAM requests, back to IDLE.
- **Reset mid-pass:** assert rst_n low during the second read of a pass → all outputs 0, empty=1. A new cfg_start then runs cleanly from address 0.
